ofmaps_stream_writer: RTL
=========================

# ofmaps_stream_writer

Output-side counterpart of the accelerator's control unit. It accepts the int8 output-feature-map bytes the MAC array produces for a COMPUTE instruction, packs them into 32-bit AXI4-Stream beats with TLAST on the layer's final beat, and generates the status word returned to the host on `axi_control_3`. It sits between the MAC result path and the DMA S2MM stream port.

## Interface
Parameters:
- `C_M_AXIS_TDATA_WIDTH`, 32: stream width; fixed at 32, four byte lanes.
- `CHANNEL_WIDTH`, 12: width of the output channel count.
- `SIDE_WIDTH`, 9: width of the ofmap side length.
- `PIXEL_WIDTH`, 18: pixel counter width; holds `SIDE*SIDE`, up to 261121.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse when a COMPUTE instruction is decoded.
- `ofmaps_channel` in 12: output channels per pixel; sampled on an accepted `start`.
- `ofmaps_width` in 9: ofmap side length, square map; sampled on an accepted `start`.
- `result_valid` in 1: result byte valid.
- `result_data` in 8: result byte, channel-major within a pixel, pixels in raster order.
- `result_ready` out 1: byte accepted when both `result_valid` and `result_ready` are high.
- `m_axis_tdata` out 32: packed beat.
- `m_axis_tkeep` out 4: byte-lane enables.
- `m_axis_tlast` out 1: final beat of the layer.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `status_word` out 32: drives `axi_control_3`. Bit 0 busy, bit 1 done, bit 2 start_error, bits 7:3 zero, bits 31:8 beats sent.

## Operation
- FSM states:
  - IDLE: `start` latches the config and computes total_pixels = width*width at 18 bits. If channel==0 or width==0, go to DONE. Otherwise clear the counters and go to PACK.
  - PACK: `result_ready`=1. Each accepted byte goes into lane `lane_cnt`, so the first byte lands in bits 7:0. After lane 3 or after the layer's last byte, go to SEND.
  - SEND: `m_axis_tvalid`=1 and `result_ready`=0. When `tready` is high, the beat count increments. If this was the last beat, go to DONE; otherwise clear the pack register and return to PACK.
  - DONE: one cycle, then IDLE.
- Counters: `lane_cnt`[1:0], `ch_cnt`[11:0], `pix_cnt`[17:0].
  - `ch_cnt` wraps to 0 at channel-1 and increments `pix_cnt` at that point.
  - The last byte is the one where ch_cnt==channel-1 and pix_cnt==total_pixels-1.
  - Packing is continuous across pixel boundaries. Only the final beat may be partial.
- `tkeep` = 4'hF on every beat except a partial final beat, where it is (1<<k)-1 for k valid bytes. Unused lanes of `tdata` are 0.
- Status bits:
  - busy = state is not IDLE.
  - done sets on entry to DONE and stays set until the next accepted `start`.
  - start_error sets when `start` arrives while busy; that `start` is ignored and the transfer in progress is unaffected. start_error clears on the next accepted `start`.
  - The beat count clears on an accepted `start` and saturates at 2^24-1.
- An accepted `start` in IDLE clears done, start_error and the beat count in the same cycle it latches the config.

## Timing
- Reset values:
  - state IDLE.
  - `result_ready`, `m_axis_tvalid`, `m_axis_tlast` = 0.
  - `m_axis_tdata` = 0, `m_axis_tkeep` = 0, `status_word` = 0.
  - All counters 0.
- Reset mid-transfer discards the partial beat and the counters immediately. Nothing resumes.
- `start` to first `result_ready`: 1 cycle.
- The 4th byte accepted in cycle n gives `m_axis_tvalid` high in cycle n+1.
- Throughput: 4 bytes per 5 cycles at best; no overlap of PACK and SEND.
- AXIS rule: once `tvalid` is high, `tdata`, `tkeep` and `tlast` hold stable until `tready` is high. `tvalid` never drops without a handshake.
- All outputs are registered or decoded from state only; no combinational path from `m_axis_tready` to `result_ready`.
- DONE is entered the cycle after the last handshake. `status_word` done reads 1 in that same cycle and stays 1 after returning to IDLE.
- Zero-size layer: DONE is entered the cycle after `start`, with no beats sent.

## Structure
- Shared package `cnn_accel_pkg` holds:
  - `INST_COMPUTE` (87).
  - Status bit positions: BUSY=0, DONE=1, START_ERR=2, beat-count LSB=8.
  - FSM state encodings, shared with the control unit's package entries.
- One sub-module, `ofmaps_byte_packer`. It contains the 32-bit pack register, `lane_cnt` and tkeep generation. Its interface is a byte write, a clear, and the pack register plus lane count as outputs.
- The FSM, the layer counters and the status register stay in the top module.

## Test plan
- ch=4, w=1, bytes 01..04, `tready` high → one beat, tdata 0x04030201, tkeep F, tlast 1; status 0x00000102 after DONE.
- ch=3, w=2, bytes 01..0C → three beats 0x04030201, 0x08070605, 0x0C0B0A09; tlast only on the third; beat count 3.
- ch=5, w=1 → beat 1: tdata 0x04030201, tkeep F, tlast 0. Beat 2: tdata 0x00000005, tkeep 1, tlast 1.
- `tready` low for 3 cycles during SEND → tdata, tkeep, tlast and tvalid stable; `result_ready` 0 throughout; no byte lost.
- `start` pulsed mid-transfer → status bit 2 set, stream identical to a run without the pulse. A later `start` in IDLE clears bit 2.
- ch=0, w=7 → no beats; done 1 one cycle after `start`. Separately, `rst_n` low mid-PACK → all outputs 0 and state IDLE. A fresh ch=4, w=1 run then produces the correct single beat.

Source files
------------

// File: rtl/cnn_accel_pkg.sv
// Shared accelerator definitions: instruction opcodes, status word layout and
// the ofmaps writer state encodings used by the control unit as well.
package cnn_accel_pkg;

  localparam logic [7:0] INST_COMPUTE = 8'd87;

  localparam int STAT_BUSY_BIT      = 0;
  localparam int STAT_DONE_BIT      = 1;
  localparam int STAT_START_ERR_BIT = 2;
  localparam int STAT_BEAT_LSB      = 8;
  localparam int STAT_BEAT_WIDTH    = 24;

  localparam logic [1:0] OSW_IDLE = 2'd0;
  localparam logic [1:0] OSW_PACK = 2'd1;
  localparam logic [1:0] OSW_SEND = 2'd2;
  localparam logic [1:0] OSW_DONE = 2'd3;

endpackage

// File: rtl/ofmaps_stream_writer_if.sv
// Result byte stream from the MAC array and AXI4-Stream master towards the DMA.
interface ofmaps_stream_writer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    result_valid;
  logic [7:0]              result_data;
  logic                    result_ready;
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  modport master (
    input  result_valid, result_data, m_axis_tready,
    output result_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output result_valid, result_data, m_axis_tready,
    input  result_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/ofmaps_byte_packer.sv
// Packs bytes little-endian into a 32-bit word; the keep mask records which
// lanes have been written so a short final beat is flagged correctly.
module ofmaps_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic [31:0] pack_data,
  output logic [3:0]  pack_keep,
  output logic [1:0]  lane_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data <= '0;
      pack_keep <= '0;
      lane_cnt  <= '0;
    end else if (clear) begin
      pack_data <= '0;
      pack_keep <= '0;
      lane_cnt  <= '0;
    end else if (wr_en) begin
      pack_data[{lane_cnt, 3'b000} +: 8] <= wr_data;
      pack_keep[lane_cnt]                <= 1'b1;
      lane_cnt                           <= lane_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/ofmaps_stream_writer.sv
// Collects output-feature-map bytes, emits packed AXI4-Stream beats with TLAST
// on the layer's final beat and maintains the host-visible status word.
module ofmaps_stream_writer
  import cnn_accel_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int CHANNEL_WIDTH        = 12,
  parameter int SIDE_WIDTH           = 9,
  parameter int PIXEL_WIDTH          = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CHANNEL_WIDTH-1:0] ofmaps_channel,
  input  logic [SIDE_WIDTH-1:0]    ofmaps_width,
  ofmaps_stream_writer_if.master   bus,
  output logic [31:0]              status_word
);

  logic [1:0]                      state;
  logic [CHANNEL_WIDTH-1:0]        ch_reg;
  logic [PIXEL_WIDTH-1:0]          total_pixels;
  logic [CHANNEL_WIDTH-1:0]        ch_cnt;
  logic [PIXEL_WIDTH-1:0]          pix_cnt;
  logic                            last_flag;
  logic                            done_flag;
  logic                            start_err;
  logic [STAT_BEAT_WIDTH-1:0]      beat_cnt;

  logic [C_M_AXIS_TDATA_WIDTH-1:0] pack_data;
  logic [3:0]                      pack_keep;
  logic [1:0]                      lane_cnt;

  logic accept_start;
  logic zero_size;
  logic byte_fire;
  logic beat_fire;
  logic last_byte;
  logic ch_wrap;
  logic packer_clear;

  assign accept_start = start && (state == OSW_IDLE);
  assign zero_size    = (ofmaps_channel == '0) || (ofmaps_width == '0);
  assign byte_fire    = (state == OSW_PACK) && bus.result_valid;
  assign beat_fire    = (state == OSW_SEND) && bus.m_axis_tready;
  assign ch_wrap      = (ch_cnt == ch_reg - CHANNEL_WIDTH'(1));
  assign last_byte    = ch_wrap && (pix_cnt == total_pixels - PIXEL_WIDTH'(1));
  assign packer_clear = accept_start || (beat_fire && !last_flag);

  ofmaps_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (packer_clear),
    .wr_en     (byte_fire),
    .wr_data   (bus.result_data),
    .pack_data (pack_data),
    .pack_keep (pack_keep),
    .lane_cnt  (lane_cnt)
  );

  // Layer sequencing; PACK and SEND never overlap so the packer is idle while a beat waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= OSW_IDLE;
      ch_reg       <= '0;
      total_pixels <= '0;
      ch_cnt       <= '0;
      pix_cnt      <= '0;
      last_flag    <= 1'b0;
    end else begin
      case (state)
        OSW_IDLE: begin
          if (start) begin
            ch_reg       <= ofmaps_channel;
            total_pixels <= PIXEL_WIDTH'(ofmaps_width) * PIXEL_WIDTH'(ofmaps_width);
            ch_cnt       <= '0;
            pix_cnt      <= '0;
            last_flag    <= 1'b0;
            state        <= zero_size ? OSW_DONE : OSW_PACK;
          end
        end
        OSW_PACK: begin
          if (byte_fire) begin
            if (ch_wrap) begin
              ch_cnt  <= '0;
              pix_cnt <= pix_cnt + PIXEL_WIDTH'(1);
            end else begin
              ch_cnt  <= ch_cnt + CHANNEL_WIDTH'(1);
            end
            if ((lane_cnt == 2'd3) || last_byte) begin
              last_flag <= last_byte;
              state     <= OSW_SEND;
            end
          end
        end
        OSW_SEND: begin
          if (bus.m_axis_tready) begin
            state <= last_flag ? OSW_DONE : OSW_PACK;
          end
        end
        default: state <= OSW_IDLE;
      endcase
    end
  end

  // Sticky status: only an accepted start clears done, start_error and the beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_flag <= 1'b0;
      start_err <= 1'b0;
      beat_cnt  <= '0;
    end else if (accept_start) begin
      done_flag <= zero_size;
      start_err <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (start) begin
        start_err <= 1'b1;
      end
      if (beat_fire && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + STAT_BEAT_WIDTH'(1);
      end
      if (beat_fire && last_flag) begin
        done_flag <= 1'b1;
      end
    end
  end

  assign bus.result_ready  = (state == OSW_PACK);
  assign bus.m_axis_tvalid = (state == OSW_SEND);
  assign bus.m_axis_tdata  = (state == OSW_SEND) ? pack_data : '0;
  assign bus.m_axis_tkeep  = (state == OSW_SEND) ? pack_keep : '0;
  assign bus.m_axis_tlast  = (state == OSW_SEND) && last_flag;

  always_comb begin
    status_word                                      = '0;
    status_word[STAT_BUSY_BIT]                       = (state != OSW_IDLE);
    status_word[STAT_DONE_BIT]                       = done_flag;
    status_word[STAT_START_ERR_BIT]                  = start_err;
    status_word[STAT_BEAT_LSB +: STAT_BEAT_WIDTH]    = beat_cnt;
  end

endmodule
